// File: rtl/crc_check.sv
// Receive-side CRC-32 checker and stripper for a 2-bit framed stream.
// Runs a 2-bit-parallel LFSR over each frame, removes the trailing 16-dibit
// CRC field through a 17-cycle delay line, and flags the frame good or bad
// in the same cycle as the last payload dibit leaves on d_out_o.
module crc_check #(
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] RESIDUE = 32'hC704DD7B,
    parameter int unsigned MIN_LEN = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] d_i,
    input  logic       sop_i,
    input  logic       eop_i,
    output logic [1:0] d_out_o,
    output logic       sop_out_o,
    output logic       eop_out_o,
    output logic       crc_ok_o,
    output logic       crc_err_o
);

    localparam int unsigned Stages = 16;
    localparam logic [4:0]  MinLen = 5'(MIN_LEN);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                   state_q, state_d;
    logic [31:0]              crc_q, crc_d, crc_base, crc_step;
    logic                     f0, f1;
    logic [4:0]               len_q, len_d;
    logic [Stages-1:0][1:0]   data_q, data_d;
    logic [Stages-1:0]        tag_q, tag_d;
    logic                     in_frame, frame_end, abort, long_frame, crc_match;
    logic [1:0]               d_out_q;
    logic                     sop_out_q, eop_out_q, crc_ok_q, crc_err_q;

    // One 2-bit LFSR step; a sop always restarts from the all-ones seed.
    always_comb begin
        crc_base    = sop_i ? 32'hFFFF_FFFF : crc_q;
        f1          = crc_base[31] ^ d_i[0];
        f0          = crc_base[30] ^ d_i[1];
        crc_step    = '0;
        crc_step[0] = f0;
        crc_step[1] = f0 ^ f1;
        for (int i = 2; i < 32; i++) begin
            crc_step[i] = crc_base[i-2] ^ (f0 & POLY[i]) ^ (f1 & POLY[i-1]);
        end
    end

    // Frame tracking, length count, delay-line shifting and status decode.
    always_comb begin
        in_frame  = sop_i || (state_q == StBusy);
        frame_end = in_frame && eop_i;
        abort     = sop_i && (state_q == StBusy);

        state_d = state_q;
        if (sop_i) begin
            state_d = StBusy;
        end
        // eop wins so a sop+eop dibit closes immediately as a 1-dibit frame
        if (frame_end) begin
            state_d = StIdle;
        end

        crc_d = in_frame ? crc_step : crc_q;

        len_d = len_q;
        if (sop_i) begin
            len_d = 5'd1;
        end else if ((state_q == StBusy) && (len_q < MinLen)) begin
            len_d = len_q + 5'd1;
        end

        // len_d includes the current dibit, so it is the full frame length on eop
        long_frame = (len_d >= MinLen);
        crc_match  = (crc_step == RESIDUE);

        data_d = {data_q[Stages-2:0], d_i};
        tag_d  = {tag_q[Stages-2:0], sop_i};
        // An abort drops the old frame's pending sop tags; only the new one survives
        if (abort) begin
            tag_d = {{(Stages-1){1'b0}}, 1'b1};
        end
        // A short frame must never produce a sop_out
        if (frame_end && !long_frame) begin
            tag_d = '0;
        end
    end

    // State, LFSR, counter and delay-line registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            crc_q   <= 32'hFFFF_FFFF;
            len_q   <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    // Registered outputs; the stage-16 entry is the last payload dibit on eop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out_q   <= '0;
            sop_out_q <= 1'b0;
            eop_out_q <= 1'b0;
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            d_out_q   <= data_q[Stages-1];
            sop_out_q <= tag_q[Stages-1];
            eop_out_q <= frame_end && long_frame;
            crc_ok_q  <= frame_end && long_frame && crc_match;
            crc_err_q <= frame_end && (!long_frame || !crc_match);
        end
    end

    assign d_out_o   = d_out_q;
    assign sop_out_o = sop_out_q;
    assign eop_out_o = eop_out_q;
    assign crc_ok_o  = crc_ok_q;
    assign crc_err_o = crc_err_q;

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: table of single-frame cases plus
// hand-written back-to-back, abort and mid-frame reset sequences.
module tb_crc_check;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] d;
    logic       sop, eop;
    logic [1:0] d_out;
    logic       sop_out, eop_out, crc_ok, crc_err;

    crc_check dut (
        .clk       (clk),
        .rst       (rst),
        .d_i       (d),
        .sop_i     (sop),
        .eop_i     (eop),
        .d_out_o   (d_out),
        .sop_out_o (sop_out),
        .eop_out_o (eop_out),
        .crc_ok_o  (crc_ok),
        .crc_err_o (crc_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Output event logs, recorded away from the active edge
    int       sop_q[$], eop_q[$], ok_q[$], err_q[$];
    logic [1:0] pay_q[$];
    logic     cap_q = 1'b0;
    int       both_cnt = 0;
    wire      cap_now = sop_out || cap_q;

    always @(negedge clk) begin
        if (sop_out) sop_q.push_back(cyc);
        if (eop_out) eop_q.push_back(cyc);
        if (crc_ok)  ok_q.push_back(cyc);
        if (crc_err) err_q.push_back(cyc);
        if (cap_now) pay_q.push_back(d_out);
        cap_q <= cap_now && !eop_out;
        if (crc_ok && crc_err) both_cnt <= both_cnt + 1;
    end

    logic [1:0] tx_q[$];
    logic [1:0] exp_pay[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? POLY : 32'h0);
    endfunction

    function automatic logic [1:0] pat_dibit(input int pat, input int i);
        case (pat)
            0:       return 2'b00;
            1:       return 2'(3 * i + 1);
            default: return 2'(i ^ (i >> 2));
        endcase
    endfunction

    // Build a frame into tx_q: raw_len>0 gives raw dibits with no CRC field
    task automatic build(input int n_pay, input int pat, input bit flip, input int raw_len);
        logic [31:0] c;
        logic [1:0]  p;
        tx_q.delete();
        exp_pay.delete();
        if (raw_len > 0) begin
            for (int i = 0; i < raw_len; i++) tx_q.push_back(pat_dibit(pat, i));
        end else begin
            c = 32'hFFFF_FFFF;
            for (int i = 0; i < n_pay; i++) begin
                p = pat_dibit(pat, i);
                c = crc_bit(c, p[0]);
                c = crc_bit(c, p[1]);
                tx_q.push_back(p);
            end
            // Complemented CRC, MSB first on the wire
            for (int j = 0; j < 16; j++) begin
                p[0] = ~c[31 - 2*j];
                p[1] = ~c[30 - 2*j];
                tx_q.push_back(p);
            end
            if (flip) begin
                p = tx_q[2];
                p[1] = ~p[1];
                tx_q[2] = p;
            end
            for (int i = 0; i < n_pay; i++) exp_pay.push_back(tx_q[i]);
        end
    endtask

    task automatic send(input bit with_eop, output int s, output int e);
        s = 0;
        e = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            @(posedge clk); #1;
            d   = tx_q[i];
            sop = (i == 0);
            eop = with_eop && (i == tx_q.size() - 1);
            if (i == 0) s = cyc;
            e = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            d   = 2'b00;
            sop = 1'b0;
            eop = 1'b0;
        end
    endtask

    task automatic clear_logs();
        sop_q.delete(); eop_q.delete(); ok_q.delete(); err_q.delete(); pay_q.delete();
    endtask

    task automatic check_payload(input string name);
        int mism;
        mism = 0;
        check({name, ".pay_cnt"}, pay_q.size(), exp_pay.size());
        for (int i = 0; i < pay_q.size() && i < exp_pay.size(); i++) begin
            if (pay_q[i] != exp_pay[i]) mism++;
        end
        check({name, ".pay_mismatches"}, mism, 0);
    endtask

    typedef struct {
        string name;
        int    n_pay;
        int    raw_len;
        bit    flip;
        int    pat;
        int    exp_sop;   // sop_out offset from sop, -1 = none
        int    exp_eop;   // eop_out offset from sop, -1 = none
        int    exp_stat;  // crc_ok/crc_err offset from sop
        int    exp_ok;
        int    exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int s, e, s1, e1, s2, e2, st;
        logic [31:0] all_out;

        vecs[0] = '{"good_zero", 4,  0,  1'b0, 0, 17, 20, 20, 1, 0};
        vecs[1] = '{"corrupt",   4,  0,  1'b1, 0, 17, 20, 20, 0, 1};
        vecs[2] = '{"minimum",   1,  0,  1'b0, 1, 17, 17, 17, 1, 0};
        vecs[3] = '{"short",     0,  12, 1'b0, 2, -1, -1, 12, 0, 1};
        vecs[4] = '{"long",      24, 0,  1'b0, 2, 17, 40, 40, 1, 0};
        vecs[5] = '{"one_dibit", 0,  1,  1'b0, 1, -1, -1, 1,  0, 1};

        rst = 1'b1; d = 2'b00; sop = 1'b0; eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all_out = 32'({d_out, sop_out, eop_out, crc_ok, crc_err});
        check("reset_outputs", int'(all_out), 0);
        rst = 1'b0;
        idle(3);

        for (int v = 0; v < 6; v++) begin
            build(vecs[v].n_pay, vecs[v].pat, vecs[v].flip, vecs[v].raw_len);
            clear_logs();
            send(1'b1, s, e);
            idle(25);
            check({vecs[v].name, ".sop_cnt"}, sop_q.size(), (vecs[v].exp_sop < 0) ? 0 : 1);
            if (sop_q.size() > 0 && vecs[v].exp_sop >= 0)
                check({vecs[v].name, ".sop_at"}, sop_q[0] - s, vecs[v].exp_sop);
            check({vecs[v].name, ".eop_cnt"}, eop_q.size(), (vecs[v].exp_eop < 0) ? 0 : 1);
            if (eop_q.size() > 0 && vecs[v].exp_eop >= 0)
                check({vecs[v].name, ".eop_at"}, eop_q[0] - s, vecs[v].exp_eop);
            check({vecs[v].name, ".ok_cnt"}, ok_q.size(), vecs[v].exp_ok);
            check({vecs[v].name, ".err_cnt"}, err_q.size(), vecs[v].exp_err);
            st = (ok_q.size() > 0) ? ok_q[0] : ((err_q.size() > 0) ? err_q[0] : s - 1);
            check({vecs[v].name, ".stat_at"}, st - s, vecs[v].exp_stat);
            check_payload(vecs[v].name);
        end

        // Back-to-back: 32-dibit then 20-dibit frame, second sop right after eop
        clear_logs();
        build(16, 1, 1'b0, 0);
        for (int i = 0; i < 16; i++) exp_pay.push_back(tx_q[i]);
        exp_pay.delete();
        for (int i = 0; i < 16; i++) exp_pay.push_back(tx_q[i]);
        send(1'b1, s1, e1);
        begin
            logic [1:0] first_pay[$];
            first_pay = exp_pay;
            build(4, 2, 1'b0, 0);
            for (int i = 0; i < 4; i++) first_pay.push_back(exp_pay[i]);
            exp_pay = first_pay;
        end
        send(1'b1, s2, e2);
        idle(25);
        check("b2b.second_sop_at_e1p1", s2 - e1, 1);
        check("b2b.sop_cnt", sop_q.size(), 2);
        if (sop_q.size() == 2) begin
            check("b2b.sop1_at", sop_q[0] - s1, 17);
            check("b2b.sop2_after_e1", sop_q[1] - e1, 18);
        end
        check("b2b.eop_cnt", eop_q.size(), 2);
        if (eop_q.size() == 2) begin
            check("b2b.eop1_at", eop_q[0] - e1, 1);
            check("b2b.eop2_at", eop_q[1] - e2, 1);
        end
        check("b2b.ok_cnt", ok_q.size(), 2);
        check("b2b.err_cnt", err_q.size(), 0);
        check_payload("b2b");

        // Abort: 25 dibits with no eop, then a fresh good 40-dibit frame
        clear_logs();
        build(0, 1, 1'b0, 25);
        send(1'b0, s1, e1);
        build(24, 2, 1'b0, 0);
        send(1'b1, s2, e2);
        idle(25);
        check("abort.restart_at", s2 - s1, 25);
        check("abort.sop_cnt", sop_q.size(), 2);
        if (sop_q.size() == 2) begin
            check("abort.sop_old_at", sop_q[0] - s1, 17);
            check("abort.sop_new_at", sop_q[1] - s2, 17);
        end
        check("abort.eop_cnt", eop_q.size(), 1);
        if (eop_q.size() == 1) check("abort.eop_at", eop_q[0] - s2, 40);
        check("abort.ok_cnt", ok_q.size(), 1);
        if (ok_q.size() == 1) check("abort.ok_at", ok_q[0] - s2, 40);
        check("abort.err_cnt", err_q.size(), 0);

        // Reset mid-frame, after payload has started appearing on d_out
        build(24, 1, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            d   = tx_q[i];
            sop = (i == 0);
            eop = 1'b0;
        end
        check("rst.pre_d_out", int'(d_out), int'(tx_q[2]));
        #2 rst = 1'b1;
        #1;
        all_out = 32'({d_out, sop_out, eop_out, crc_ok, crc_err});
        check("rst.outputs_cleared", int'(all_out), 0);
        idle(2);
        rst = 1'b0;
        clear_logs();
        for (int i = 20; i < 40; i++) begin
            @(posedge clk); #1;
            d   = tx_q[i];
            sop = 1'b0;
            eop = (i == 39);
        end
        idle(25);
        check("rst.sop_cnt", sop_q.size(), 0);
        check("rst.eop_cnt", eop_q.size(), 0);
        check("rst.ok_cnt", ok_q.size(), 0);
        check("rst.err_cnt", err_q.size(), 0);

        check("ok_err_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
